// File: rtl/uart_pkg.sv
// Shared constants and the stored entry layout for the UART receive path.
package uart_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // One queued character: the framing-error tag sits above the data bits.
    typedef struct packed {
        logic                 ferr;
        logic [DEF_WIDTH-1:0] data;
    } rx_entry_t;

    // Bits needed to hold one {ferr, data} entry for a given data width.
    function automatic int entry_bits(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port, so the head entry is visible without a read cycle.
module fifo_mem
    import uart_pkg::*;
#(
    parameter int ENTRY_W = entry_bits(DEF_WIDTH),
    parameter int DEPTH   = DEF_DEPTH,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write the incoming entry; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the entry at the read pointer.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive character FIFO with first-word-fall-through output, a framing-error
// tag per entry and a sticky overflow flag for characters dropped while full.
module rx_byte_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_ferr,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_ferr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = entry_bits(WIDTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count_q;
    logic               overflow_q;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               push;
    logic               pop;
    logic               drop;

    // Handshake decode: a pop frees a slot, so a full queue still accepts
    // a character arriving in the same cycle as a pop.
    always_comb begin
        out_valid = (count_q != '0);
        full      = (count_q == FULL_CNT);
        pop       = out_valid & out_ready;
        push      = rx_valid & (~full | pop);
        drop      = rx_valid & full & ~pop;
        wr_entry  = {rx_ferr, rx_data};
        out_ferr  = rd_entry[ENTRY_W-1];
        out_data  = rd_entry[WIDTH-1:0];
        count     = count_q;
        overflow  = overflow_q;
    end

    fifo_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

endmodule
